// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Default cycle counts assume the 12 MHz board reference clock.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  localparam int unsigned RETRY_MAX          = 15;
  localparam int unsigned DEF_PLL_RST_CYCLES = 12;     // 1 us
  localparam int unsigned DEF_TIMEOUT_CYCLES = 12000;  // 1 ms
  localparam int unsigned DEF_SETTLE_CYCLES  = 1200;   // 100 us
  localparam int unsigned DEF_TICK_DIV       = 12000;  // 1 kHz

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a settled lock, and releases the PLL-domain reset.
// Optional heartbeat tick is built only when PLL_SUP_TICK_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       tick
);

  localparam int unsigned MAX_CYC = max3(PLL_RST_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic           lock_s;
  pll_sup_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]     retry_q, retry_d;
  logic           pll_resetb_q, sys_rst_q, ready_q;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (retry_q != 4'(RETRY_MAX)) retry_d = retry_q + 4'd1;
        end
      end
      SETTLE: begin
        // Lock loss wins even on the final settle cycle.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= 4'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      // Decoded from next state so outputs move on the transition edge.
      pll_resetb_q <= (state_d != PLL_RST);
      sys_rst_q    <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign retry_cnt  = retry_q;

`ifdef PLL_SUP_TICK_EN
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick_q;

  // Gated on next state so tick can never be high while ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (state_d != RUN) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
      tick_q     <= 1'b0;
    end
  end

  assign tick = tick_q;
`else
  logic unused_tick_div;
  assign unused_tick_div = ^TICK_DIV;
  assign tick            = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (small cycle parameters).
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       pll_resetb;
  logic       sys_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       tick;

  int checks   = 0;
  int failures = 0;

`ifdef PLL_SUP_TICK_EN
  localparam bit TickEn = 1'b1;
`else
  localparam bit TickEn = 1'b0;
`endif

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .TIMEOUT_CYCLES (20),
    .SETTLE_CYCLES  (8),
    .TICK_DIV       (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .pll_resetb (pll_resetb),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lock;
    int         adv;
    logic       resetb;
    logic       srst;
    logic       rdy;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pll_resetb"}, {3'b0, pll_resetb}, 4'd0);
    check({tag, " sys_rst"},    {3'b0, sys_rst},    4'd1);
    check({tag, " ready"},      {3'b0, ready},      4'd0);
    check({tag, " retry_cnt"},  retry_cnt,          4'd0);
    check({tag, " tick"},       {3'b0, tick},       4'd0);
  endtask

  initial begin
    // Edge counts below are taken from the edge just before the input change.
    vecs[0] = '{lock: 1'b0, adv: 3,  resetb: 1'b0, srst: 1'b1, rdy: 1'b0, retry: 4'd0};
    vecs[1] = '{lock: 1'b0, adv: 1,  resetb: 1'b1, srst: 1'b1, rdy: 1'b0, retry: 4'd0};
    vecs[2] = '{lock: 1'b0, adv: 3,  resetb: 1'b1, srst: 1'b1, rdy: 1'b0, retry: 4'd0};
    // Lock raised: 2 sync + 1 WAIT_LOCK exit + 8 settle = ready on the 11th edge.
    vecs[3] = '{lock: 1'b1, adv: 10, resetb: 1'b1, srst: 1'b1, rdy: 1'b0, retry: 4'd0};
    vecs[4] = '{lock: 1'b1, adv: 1,  resetb: 1'b1, srst: 1'b0, rdy: 1'b1, retry: 4'd0};
    vecs[5] = '{lock: 1'b1, adv: 3,  resetb: 1'b1, srst: 1'b0, rdy: 1'b1, retry: 4'd0};

    rst      = 1'b1;
    pll_lock = 1'b0;
    adv(3);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pll_lock = vecs[i].lock;
      adv(vecs[i].adv);
      check($sformatf("vec%0d pll_resetb", i), {3'b0, pll_resetb}, {3'b0, vecs[i].resetb});
      check($sformatf("vec%0d sys_rst", i),    {3'b0, sys_rst},    {3'b0, vecs[i].srst});
      check($sformatf("vec%0d ready", i),      {3'b0, ready},      {3'b0, vecs[i].rdy});
      check($sformatf("vec%0d retry_cnt", i),  retry_cnt,          vecs[i].retry);
    end

    // Ready rose 3 edges ago; ticks expected 4, 9, 14 ... edges after that.
    for (int off = 4; off < 14; off++) begin
      adv(1);
      check($sformatf("tick off%0d", off), {3'b0, tick},
            {3'b0, TickEn && ((off - 4) % 5 == 0)});
    end

    // Lock loss in RUN.
    pll_lock = 1'b0;
    adv(2);
    check("loss early sys_rst", {3'b0, sys_rst}, 4'd0);
    check("loss early ready",   {3'b0, ready},   4'd1);
    adv(1);
    check("loss sys_rst",    {3'b0, sys_rst},    4'd1);
    check("loss ready",      {3'b0, ready},      4'd0);
    check("loss pll_resetb", {3'b0, pll_resetb}, 4'd1);
    check("loss retry_cnt",  retry_cnt,          4'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("loss tick%0d", i), {3'b0, tick}, 4'd0);
      adv(1);
      check($sformatf("loss resetb%0d", i), {3'b0, pll_resetb}, 4'd1);
    end

    // Settle glitch: FSM sees lock_s=0 at SETTLE count 5.
    pll_lock = 1'b1;
    adv(6);
    pll_lock = 1'b0;
    adv(1);
    pll_lock = 1'b1;
    adv(4);
    check("glitch no early ready", {3'b0, ready}, 4'd0);
    adv(6);
    check("glitch ready before", {3'b0, ready},   4'd0);
    check("glitch sys_rst before", {3'b0, sys_rst}, 4'd1);
    adv(1);
    check("glitch ready after",   {3'b0, ready},   4'd1);
    check("glitch sys_rst after", {3'b0, sys_rst}, 4'd0);

    // Asynchronous reset mid-cycle while in RUN.
    adv(2);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    adv(2);
    check_reset_vals("async held");
    pll_lock = 1'b0;
    rst      = 1'b0;

    // Timeout retries with lock held low.
    adv(4);
    check("to resetb up",   {3'b0, pll_resetb}, 4'd1);
    check("to retry0",      retry_cnt,          4'd0);
    adv(19);
    check("to resetb wait", {3'b0, pll_resetb}, 4'd1);
    check("to retry0 wait", retry_cnt,          4'd0);
    adv(1);
    check("to resetb low",  {3'b0, pll_resetb}, 4'd0);
    check("to retry1",      retry_cnt,          4'd1);
    adv(3);
    check("to resetb low3", {3'b0, pll_resetb}, 4'd0);
    adv(1);
    check("to resetb high", {3'b0, pll_resetb}, 4'd1);
    adv(20);
    check("to retry2",      retry_cnt,          4'd2);
    check("to resetb2",     {3'b0, pll_resetb}, 4'd0);
    for (int k = 3; k <= 17; k++) begin
      adv(24);
      check($sformatf("to retry%0d", k), retry_cnt, 4'((k > 15) ? 15 : k));
    end
    check("to sys_rst", {3'b0, sys_rst}, 4'd1);
    check("to ready",   {3'b0, ready},   4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
